// File: rtl/sha256_msg_padder_if.sv
// rtl/sha256_msg_padder_if.sv - 512-bit padded block stream between padder and hash core
interface sha256_msg_padder_if;
    logic [511:0] block_data;
    logic         block_valid;
    logic         block_ready;
    logic         block_last;

    modport master (
        output block_data,
        output block_valid,
        output block_last,
        input  block_ready
    );

    modport slave (
        input  block_data,
        input  block_valid,
        input  block_last,
        output block_ready
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - fetches a message from memory and presents SHA-256 padded 512-bit blocks
module sha256_msg_padder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [15:0]                 message_addr,
    output logic                        mem_clk,
    output logic                        mem_we,
    output logic [15:0]                 mem_addr,
    input  logic [31:0]                 mem_read_data,
    output logic                        busy,
    output logic                        done,
    sha256_msg_padder_if.master         blk
);
    localparam int          NB     = (NUM_OF_WORDS + 18) / 16;
    localparam logic [31:0] LEN_LO = 32'(NUM_OF_WORDS * 32);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} state_t;

    state_t      state;
    logic [15:0] base;
    logic [6:0]  blk_idx;
    logic [4:0]  cnt;
    logic [31:0] buffer [16];
    logic [4:0]  m_cur;
    logic [4:0]  m_next;
    logic        is_last;
    logic [15:0] next_addr;
    logic [3:0]  slot;
    int          g;
    logic [31:0] word;

    // Number of message (non-padding) words that fall inside block b.
    function automatic int words_in(input int b);
        int rem;
        rem = NUM_OF_WORDS - 16 * b;
        if (rem <= 0)
            return 0;
        if (rem > 16)
            return 16;
        return rem;
    endfunction

    assign mem_clk   = clk;
    assign mem_we    = 1'b0;
    assign is_last   = (int'(blk_idx) == NB - 1);
    assign next_addr = base + {5'd0, blk_idx + 7'd1, 4'd0};
    assign slot      = 4'(cnt - 5'd1);

    // Message-word counts for the current and the following block.
    always_comb begin
        m_cur  = 5'(words_in(int'(blk_idx)));
        m_next = 5'(words_in(int'(blk_idx) + 1));
    end

    // Assemble the presented block: buffered message words, the 0x80000000 marker, zeros, length.
    always_comb begin
        blk.block_data = '0;
        g              = 0;
        word           = '0;
        for (int w = 0; w < 16; w++) begin
            g = 16 * int'(blk_idx) + w;
            if (g < NUM_OF_WORDS)
                word = buffer[w];
            else if (g == NUM_OF_WORDS)
                word = 32'h8000_0000;
            else if (is_last && w == 15)
                word = LEN_LO;
            else
                word = 32'h0;
            blk.block_data[32*w +: 32] = word;
        end
    end

    // Capture returning memory words; data lags the address by one edge, so slot = cnt-1.
    always_ff @(posedge clk) begin
        if (state == FETCH && cnt != 5'd0)
            buffer[slot] <= mem_read_data;
    end

    // Control FSM: fetch each block's message words, present the block, pulse done at the end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            base            <= 16'h0;
            mem_addr        <= 16'h0;
            blk_idx         <= 7'd0;
            cnt             <= 5'd0;
            blk.block_valid <= 1'b0;
            blk.block_last  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base     <= message_addr;
                        mem_addr <= message_addr;
                        blk_idx  <= 7'd0;
                        cnt      <= 5'd0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    cnt <= cnt + 5'd1;
                    // Hold the address on the last word so no read beyond the block is issued.
                    if (5'(cnt + 5'd1) < m_cur)
                        mem_addr <= mem_addr + 16'd1;
                    if (cnt == m_cur) begin
                        cnt             <= 5'd0;
                        blk.block_valid <= 1'b1;
                        blk.block_last  <= is_last;
                        state           <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (blk.block_ready) begin
                        if (is_last) begin
                            blk.block_valid <= 1'b0;
                            blk.block_last  <= 1'b0;
                            done            <= 1'b1;
                            state           <= FINISH;
                        end else begin
                            blk_idx  <= blk_idx + 7'd1;
                            mem_addr <= next_addr;
                            // A block made only of padding needs no fetch.
                            if (m_next == 5'd0) begin
                                blk.block_last <= (int'(blk_idx) + 1 == NB - 1);
                            end else begin
                                blk.block_valid <= 1'b0;
                                blk.block_last  <= 1'b0;
                                state           <= FETCH;
                            end
                        end
                    end
                end
                FINISH: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    mem_addr <= base;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - directed self-checking bench for sha256_msg_padder
module tb_sha256_msg_padder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        ready;
    logic [15:0] message_addr;
    int          sel;
    int          checks = 0;
    int          errors = 0;
    logic [511:0] last_blk;

    always #5 clk = ~clk;

    logic        start20, start13, start16;
    logic        mc20, mc13, mc16, we20, we13, we16;
    logic [15:0] addr20, addr13, addr16;
    logic [31:0] rd20, rd13, rd16;
    logic        busy20, busy13, busy16, done20, done13, done16;

    sha256_msg_padder_if if20();
    sha256_msg_padder_if if13();
    sha256_msg_padder_if if16();

    assign start20 = start && sel == 20;
    assign start13 = start && sel == 13;
    assign start16 = start && sel == 16;
    assign if20.block_ready = ready;
    assign if13.block_ready = ready;
    assign if16.block_ready = ready;

    sha256_msg_padder #(.NUM_OF_WORDS(20)) u20 (
        .clk(clk), .reset_n(reset_n), .start(start20), .message_addr(message_addr),
        .mem_clk(mc20), .mem_we(we20), .mem_addr(addr20), .mem_read_data(rd20),
        .busy(busy20), .done(done20), .blk(if20)
    );
    sha256_msg_padder #(.NUM_OF_WORDS(13)) u13 (
        .clk(clk), .reset_n(reset_n), .start(start13), .message_addr(message_addr),
        .mem_clk(mc13), .mem_we(we13), .mem_addr(addr13), .mem_read_data(rd13),
        .busy(busy13), .done(done13), .blk(if13)
    );
    sha256_msg_padder #(.NUM_OF_WORDS(16)) u16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .message_addr(message_addr),
        .mem_clk(mc16), .mem_we(we16), .mem_addr(addr16), .mem_read_data(rd16),
        .busy(busy16), .done(done16), .blk(if16)
    );

    // Registered memories whose word at address a holds a.
    always @(posedge mc20) rd20 <= {16'h0, addr20};
    always @(posedge mc13) rd13 <= {16'h0, addr13};
    always @(posedge mc16) rd16 <= {16'h0, addr16};

    logic [511:0] o_data;
    logic         o_valid, o_last, o_busy, o_done, o_we;
    logic [15:0]  o_addr;

    // Route the selected instance to the observation signals.
    always_comb begin
        o_data = if20.block_data; o_valid = if20.block_valid; o_last = if20.block_last;
        o_busy = busy20; o_done = done20; o_we = we20; o_addr = addr20;
        if (sel == 13) begin
            o_data = if13.block_data; o_valid = if13.block_valid; o_last = if13.block_last;
            o_busy = busy13; o_done = done13; o_we = we13; o_addr = addr13;
        end else if (sel == 16) begin
            o_data = if16.block_data; o_valid = if16.block_valid; o_last = if16.block_last;
            o_busy = busy16; o_done = done16; o_we = we16; o_addr = addr16;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_of(input int n, input int b);
        int rem;
        rem = n - 16 * b;
        if (rem <= 0) return 0;
        if (rem > 16) return 16;
        return rem;
    endfunction

    function automatic logic [31:0] exp_word(input int n, input logic [15:0] base, input int b, input int w);
        int g;
        int nb;
        g  = 16 * b + w;
        nb = (n + 18) / 16;
        if (g < n) return {16'h0, 16'(base + 16'(g))};
        if (g == n) return 32'h8000_0000;
        if (b == nb - 1 && w == 15) return 32'(n * 32);
        return 32'h0;
    endfunction

    task automatic pulse_start(input logic [15:0] a);
        @(negedge clk);
        message_addr = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!o_valid && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!o_valid) chk("valid_timeout", 64'(0), 64'(1));
    endtask

    // Walk every block of a message; optionally stall block 0 and pulse start while it is held.
    task automatic run_blocks(input int n, input logic [15:0] base, input string nm,
                              input int hold, input bit restart);
        int nb, e, m, dn;
        logic [511:0] snap;
        logic [15:0]  sa;
        nb = (n + 18) / 16;
        if (hold > 0) ready = 1'b0;
        for (int b = 0; b < nb; b++) begin
            wait_valid(e);
            m = m_of(n, b);
            chk($sformatf("%s_b%0d_lat", nm, b), 64'(e), 64'((m == 0) ? 0 : m + 1));
            for (int w = 0; w < 16; w++)
                chk($sformatf("%s_b%0d_w%0d", nm, b, w), 64'(o_data[32*w +: 32]),
                    64'(exp_word(n, base, b, w)));
            chk($sformatf("%s_b%0d_last", nm, b), 64'(o_last), 64'(b == nb - 1));
            last_blk = o_data;
            if (b == 0 && hold > 0) begin
                snap = o_data;
                sa   = o_addr;
                for (int k = 0; k < hold; k++) begin
                    if (k == 0 && restart) begin
                        message_addr = 16'h2000;
                        start = 1'b1;
                    end
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    chk($sformatf("%s_hold%0d_valid", nm, k), 64'(o_valid), 64'(1));
                    chk($sformatf("%s_hold%0d_data", nm, k), 64'(o_data == snap), 64'(1));
                    chk($sformatf("%s_hold%0d_addr", nm, k), 64'(o_addr), 64'(sa));
                    chk($sformatf("%s_hold%0d_busy", nm, k), 64'(o_busy), 64'(1));
                end
                ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            if (o_done) dn++;
            @(posedge clk);
            #1;
        end
        chk($sformatf("%s_done_pulses", nm), 64'(dn), 64'(1));
        chk($sformatf("%s_busy_end", nm), 64'(o_busy), 64'(0));
        chk($sformatf("%s_idle_addr", nm), 64'(o_addr), 64'(base));
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        ready        = 1'b1;
        sel          = 20;
        message_addr = 16'h0;
        #12;
        chk("rst_valid", 64'(o_valid), 64'(0));
        chk("rst_busy",  64'(o_busy),  64'(0));
        chk("rst_done",  64'(o_done),  64'(0));
        chk("rst_last",  64'(o_last),  64'(0));
        chk("rst_we",    64'(o_we),    64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // N=20 with ready held high
        pulse_start(16'h1000);
        run_blocks(20, 16'h1000, "n20", 0, 1'b0);
        chk("n20_b1_w3",  64'(last_blk[127:96]),  64'h1013);
        chk("n20_b1_w4",  64'(last_blk[159:128]), 64'h8000_0000);
        chk("n20_b1_w15", 64'(last_blk[511:480]), 64'h280);

        // N=13 single block
        sel = 13;
        pulse_start(16'h1000);
        run_blocks(13, 16'h1000, "n13", 0, 1'b0);
        chk("n13_w12", 64'(last_blk[415:384]), 64'h100C);
        chk("n13_w13", 64'(last_blk[447:416]), 64'h8000_0000);
        chk("n13_w15", 64'(last_blk[511:480]), 64'h1A0);

        // N=16: second block is pure padding
        sel = 16;
        pulse_start(16'h1000);
        run_blocks(16, 16'h1000, "n16", 0, 1'b0);
        chk("n16_b1_w0",  64'(last_blk[31:0]),    64'h8000_0000);
        chk("n16_b1_w15", 64'(last_blk[511:480]), 64'h200);

        // Backpressure on block 0
        sel = 20;
        pulse_start(16'h1000);
        run_blocks(20, 16'h1000, "bp", 5, 1'b0);

        // start pulsed while block 0 is presented
        pulse_start(16'h1000);
        run_blocks(20, 16'h1000, "rs", 3, 1'b1);

        // Reset in the middle of fetching block 1, then rerun at a wrapping base
        begin
            int e;
            pulse_start(16'h1000);
            wait_valid(e);
            @(posedge clk); #1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            #2;
            reset_n = 1'b0;
            #1;
            chk("abort_valid", 64'(o_valid), 64'(0));
            chk("abort_busy",  64'(o_busy),  64'(0));
            chk("abort_done",  64'(o_done),  64'(0));
            @(negedge clk);
            reset_n = 1'b1;
            pulse_start(16'hFFF8);
            run_blocks(20, 16'hFFF8, "rr", 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream stage of the SHA-256 core.
- Reads a NUM_OF_WORDS-word message from word-addressed memory starting at message_addr.
- Applies standard SHA-256 padding: a 0x80000000 word, zero fill, then the 64-bit bit-length.
- Presents the result as a sequence of 512-bit blocks over a valid/ready handshake, so the hash core only consumes pre-formed blocks.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words. Legal range 1..1024. Block count NB = (NUM_OF_WORDS+18)/16, integer division.

Ports:
- clk  input  1  single clock; also drives mem_clk
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  begin a message; sampled only in IDLE
- message_addr  input  16  word address of message word 0; latched on the start edge
- mem_clk  output  1  equals clk
- mem_we  output  1  tied 0 (read-only)
- mem_addr  output  16  read address
- mem_read_data  input  32  data for the address sampled on the previous edge (one-cycle registered memory)
- block_data  output  512  word w of the current block on bits [32w+31:32w]
- block_valid  output  1  block_data holds a complete block
- block_ready  input  1  consumer accepts the block
- block_last  output  1  current block is block NB-1
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last block is accepted

Behaviour:
- Reset (asynchronous, any state):
  - state IDLE; block_valid, block_last, busy, done = 0; mem_we = 0.
  - Block index b = 0, word counter = 0.
  - Buffer contents are don't-care.
- States: IDLE, FETCH, PRESENT, FINISH.
- IDLE:
  - mem_addr = latched base; start=0 does nothing.
  - start=1: latch message_addr, set b=0, go to FETCH.
- FETCH:
  - m = message words in block b = min(16, max(0, NUM_OF_WORDS-16b)).
  - Drive mem_addr = base+16b+i for i = 0..m-1, one per cycle.
  - Capture each returning word into buffer slot i one edge later.
  - On the edge capturing slot m-1, go to PRESENT.
  - block_valid rises m+1 edges after the edge that entered FETCH.
  - FETCH is skipped (straight to PRESENT) when m=0.
- Padding (combinational from buffer, b and a constant), for global index g = 16b+w:
  - g < N: buffer word.
  - g == N: 0x80000000.
  - Last block, w=14: 0x00000000 (upper length).
  - Last block, w=15: N*32 mod 2^32.
  - Otherwise: 0.
- PRESENT:
  - block_valid=1; block_data and block_last are stable until the handshake.
  - block_last=1 iff b==NB-1.
  - Handshake edge = block_valid & block_ready.
  - On handshake with b<NB-1: b<=b+1; go to FETCH, or stay in PRESENT with the new block if its m=0.
  - block_valid stays 0 through FETCH.
  - On handshake with b==NB-1: go to FINISH; block_valid drops.
- FINISH: done=1 for exactly one cycle, then IDLE. start is ignored in FINISH.
- start while busy: ignored; it does not restart the fetch or re-latch the address.
- block_ready asserted while block_valid=0: no effect.
- Reset mid-FETCH or mid-PRESENT: aborts immediately; no done pulse. The next start begins cleanly from block 0.
- Back-to-back messages: start may be asserted the cycle after done; the new message is accepted on that edge.
- Arithmetic:
  - Address adds are 16-bit and wrap modulo 2^16.
  - Length constant is 64-bit; its upper word is 0 for the legal range.

Test Plan:
- N=20, mem[A+i]=0x1000+i, ready held 1:
  - Block0 words = 0x1000..0x100F, last=0.
  - Block1 w0..3 = 0x1010..0x1013, w4=0x80000000, w5..w14=0, w15=0x00000280, last=1.
  - done pulses once; first block_valid 17 edges after start.
- N=13: single block. w0..12 = memory, w13=0x80000000, w14=0, w15=0x000001A0, last=1.
- N=16: block0 = 16 memory words. Block1 presented with no FETCH cycles: w0=0x80000000, w15=0x00000200, last=1.
- Backpressure, N=20: block_ready low 5 cycles after block0 valid. block_valid and block_data are held unchanged; no new mem_addr is issued until the handshake.
- Reset asserted mid-FETCH of block1, then start with N=20 at a new base B: valid=0 and busy=0 immediately on reset. The rerun produces correct blocks from B; no stale done.
- start pulsed again during PRESENT of block0: ignored; output sequence identical to the first scenario.
